instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Fetch front-end sitting directly upstream of the pipelined CPU's IF/ID register.
- Generates sequential instruction addresses and issues them to a variable-latency instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents {instruction, PC+4} to decode with a valid/ready handshake.
- On a taken-branch redirect, flushes all buffered and in-flight instructions and restarts fetch at the target.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- MAX_OUTSTANDING, 2: maximum accepted but unanswered memory requests; minimum 1.
- RESET_PC, 32'h0000_0000: fetch address after reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- fetch_en_i  in  1  run enable; low means no new requests.
- redirect_i  in  1  branch taken in MEM; flush and redirect.
- redirect_pc_i  in  32  redirect target.
- imem_req_valid_o  out  1  request valid.
- imem_req_ready_i  in  1  memory accepts request.
- imem_req_addr_o  out  32  request address (fetch_pc).
- imem_rsp_valid_i  in  1  response valid; responses return in request order, one per cycle maximum.
- imem_rsp_data_i  in  32  response instruction word.
- dec_valid_o  out  1  head entry valid.
- dec_ready_i  in  1  decode accepts; low is a hazard stall.
- dec_instr_o  out  32  head instruction.
- dec_pc_plus4_o  out  32  head address + 4.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; stale=0; state=S_IDLE.
  - All outputs 0, except imem_req_addr_o=RESET_PC.
- FSM:
  - S_IDLE -> S_RUN when fetch_en_i=1.
  - S_RUN -> S_IDLE when fetch_en_i=0. Already-outstanding requests still complete and are buffered.
- Request issue:
  - imem_req_valid_o = (state==S_RUN) & ~redirect_i & (outstanding < MAX_OUTSTANDING) & (count + outstanding - stale < DEPTH).
  - A slot is only reserved when it is guaranteed; the FIFO can never overflow.
  - On req handshake: fetch_pc += 4 (32-bit wrap allowed) and outstanding += 1.
  - imem_req_addr_o is stable while valid is high and ready is low.
- Response:
  - Each imem_rsp_valid_i decrements outstanding.
  - If stale>0 (including stale set by a redirect in that same cycle): the response is discarded and stale decrements.
  - Otherwise: {data, addr+4} is pushed, where addr comes from an internal in-order address FIFO of MAX_OUTSTANDING entries.
  - A response and a request in the same cycle leave outstanding unchanged.
- Decode side:
  - Pop on dec_valid_o & dec_ready_i.
  - Simultaneous push and pop at count==DEPTH is legal; occupancy is unchanged.
  - Push to an empty FIFO becomes visible the next cycle: load-to-use latency is 1 cycle after the response.
  - Outputs hold while dec_ready_i=0.
- Redirect (redirect_i=1, one cycle):
  - FIFO cleared; dec_valid_o=0 next cycle.
  - fetch_pc <= redirect_pc_i.
  - stale <= outstanding - (imem_rsp_valid_i ? 1 : 0).
  - No request is issued that cycle; a same-cycle response is discarded.
  - Redirect takes priority over push and pop.
  - Back-to-back redirects are legal: the last target wins, and stale is recomputed from total outstanding.
- A redirect in S_IDLE updates fetch_pc only.
- Mid-operation reset clears everything immediately. Responses arriving after reset with outstanding=0 are ignored (an underflow guard holds the counter at 0).

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetched_o[31:0] (pushes) and perf_dropped_o[31:0] (discarded responses plus entries flushed from the FIFO).
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- FETCH_PERF_EN undefined: the ports and counters do not exist.
- All other behaviour is identical with or without the macro.

Decomposition:
- Package fetch_pkg:
  - state enum {S_IDLE, S_RUN}.
  - Entry struct {instr[31:0], pc_plus4[31:0]}.
  - INSTR_W=32.
- One sub-module fetch_fifo, parameterised for width and depth, with push, pop, clear and count. It is instantiated twice: entry FIFO (DEPTH) and address FIFO (MAX_OUTSTANDING).

Test Plan:
- Streaming: memory with 1-cycle latency, dec_ready_i=1 -> decode sees instrs at 0x0,0x4,0x8 with dec_pc_plus4_o 0x4,0x8,0xC, one per cycle after a 2-cycle startup.
- Backpressure: dec_ready_i=0 for 10 cycles -> count_o saturates at 4, imem_req_valid_o drops to 0, and no entry is lost or duplicated when ready returns.
- Redirect with flight: 2 outstanding requests, redirect_i with target 0x100 -> both responses discarded (stale 2→0), next request addr 0x100, first decoded pc_plus4 0x104.
- Redirect coincident with a response and a full FIFO -> count_o=0 next cycle, response dropped, stale=outstanding-1.
- Reset mid-stream: rst_i low while 2 requests are outstanding -> all outputs 0 immediately; after release, the first request addr is 0x0 and late responses are ignored.
- FETCH_PERF_EN: 5 fetched, redirect flushes 2 buffered and 1 in flight -> perf_fetched_o=5, perf_dropped_o=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: FSM states, FIFO entry payload,
// and a saturating adder used by the optional FETCH_PERF_EN counters.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc_plus4;
    } entry_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory and decode.
// master = fetch queue side, slave = memory/decode/pipeline-control side.
interface instr_fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    import fetch_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               fetch_en_i;
    logic               redirect_i;
    logic [INSTR_W-1:0] redirect_pc_i;
    logic               imem_req_valid_o;
    logic               imem_req_ready_i;
    logic [INSTR_W-1:0] imem_req_addr_o;
    logic               imem_rsp_valid_i;
    logic [INSTR_W-1:0] imem_rsp_data_i;
    logic               dec_valid_o;
    logic               dec_ready_i;
    logic [INSTR_W-1:0] dec_instr_o;
    logic [INSTR_W-1:0] dec_pc_plus4_o;
    logic [CNT_W-1:0]   count_o;

    modport master (
        input  fetch_en_i, redirect_i, redirect_pc_i, imem_req_ready_i,
               imem_rsp_valid_i, imem_rsp_data_i, dec_ready_i,
        output imem_req_valid_o, imem_req_addr_o, dec_valid_o,
               dec_instr_o, dec_pc_plus4_o, count_o
    );

    modport slave (
        output fetch_en_i, redirect_i, redirect_pc_i, imem_req_ready_i,
               imem_rsp_valid_i, imem_rsp_data_i, dec_ready_i,
        input  imem_req_valid_o, imem_req_addr_o, dec_valid_o,
               dec_instr_o, dec_pc_plus4_o, count_o
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push, pop, clear and occupancy; head is the oldest entry.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    // Storage and pointers; clear discards contents without touching storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: issues sequential PCs to instruction memory, buffers in-order
// responses for decode, flushes on redirect. Optional FETCH_PERF_EN adds counters.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    instr_fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched_o,
    output logic [31:0]         perf_dropped_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    state_e             state;
    state_e             state_next;
    logic [INSTR_W-1:0] fetch_pc;
    logic [INSTR_W-1:0] rsp_addr;
    logic [OUT_W-1:0]   outstanding;
    logic [OUT_W-1:0]   stale;
    logic [CNT_W-1:0]   count;
    entry_t             head;
    entry_t             push_entry;
    logic               req_valid;
    logic               req_fire;
    logic               rsp_ok;
    logic               rsp_drop;
    logic               rsp_keep;
    logic               pop;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.fetch_en_i)  state_next = S_RUN;
            S_RUN:   if (!bus.fetch_en_i) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Only reserve a request when its response is guaranteed a FIFO slot; stale
    // in-flight requests will be discarded and need no slot.
    assign req_valid = (state == S_RUN) && !bus.redirect_i
                    && (32'(outstanding) < MAX_OUTSTANDING)
                    && ((32'(count) + 32'(outstanding) - 32'(stale)) < DEPTH);
    assign req_fire  = req_valid && bus.imem_req_ready_i;

    // outstanding == 0 guards against late responses after a reset
    assign rsp_ok    = bus.imem_rsp_valid_i && (outstanding != '0);
    assign rsp_drop  = rsp_ok && (bus.redirect_i || (stale != '0));
    assign rsp_keep  = rsp_ok && !rsp_drop;
    assign pop       = bus.dec_valid_o && bus.dec_ready_i && !bus.redirect_i;

    assign push_entry = '{instr: bus.imem_rsp_data_i, pc_plus4: rsp_addr + 32'd4};

    // Addresses of accepted requests; its occupancy is the outstanding count
    fetch_fifo #(.WIDTH(INSTR_W), .DEPTH(MAX_OUTSTANDING)) u_addr_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_ok),
        .clear     (1'b0),
        .head      (rsp_addr),
        .count     (outstanding)
    );

    fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_entry_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (bus.redirect_i),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc <= RESET_PC;
            stale    <= '0;
        end else if (bus.redirect_i) begin
            fetch_pc <= bus.redirect_pc_i;
            stale    <= outstanding - OUT_W'(rsp_ok);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_ok && (stale != '0)) begin
                stale <= stale - OUT_W'(1);
            end
        end
    end

    assign bus.imem_req_valid_o = req_valid;
    assign bus.imem_req_addr_o  = fetch_pc;
    assign bus.dec_valid_o      = (count != '0);
    assign bus.dec_instr_o      = head.instr;
    assign bus.dec_pc_plus4_o   = head.pc_plus4;
    assign bus.count_o          = count;

`ifdef FETCH_PERF_EN
    // Dropped = discarded responses plus entries flushed by a redirect
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_fetched_o <= '0;
            perf_dropped_o <= '0;
        end else begin
            perf_fetched_o <= sat_add(perf_fetched_o, 32'(rsp_keep));
            perf_dropped_o <= sat_add(perf_dropped_o,
                                      32'(rsp_drop) + (bus.redirect_i ? 32'(count) : 32'd0));
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: in-order memory model plus a decode scoreboard.
module tb_instr_fetch_queue;
    import fetch_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        int          kind;   // 0 live, 1 stale after redirect, 2 orphaned by reset
    } req_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    instr_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    instr_fetch_queue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched_o (perf_fetched),
        .perf_dropped_o (perf_dropped)
`endif
    );

    req_t        pend[$];
    entry_t      exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned mem_lat = 1;
    bit          mem_hold = 1'b0;
    int          m_fetched = 0;
    int          m_dropped = 0;
    int          m_buffered = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: memory drives a response, bench updates models, then the edge.
    task automatic cycle();
        req_t   r;
        entry_t e;
        bit     delivered;
        delivered = 1'b0;
        r = '{addr: 32'h0, due: 0, kind: 0};
        if (!mem_hold && pend.size() != 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            delivered = 1'b1;
            bus.imem_rsp_valid_i = 1'b1;
            bus.imem_rsp_data_i  = instr_of(r.addr);
        end else begin
            bus.imem_rsp_valid_i = 1'b0;
            bus.imem_rsp_data_i  = 32'h0;
        end
        #1;
        if (!rst_i) begin
            exp_q.delete();
            m_fetched = 0; m_dropped = 0; m_buffered = 0;
            foreach (pend[i]) pend[i].kind = 2;
        end else begin
            if (bus.redirect_i) begin
                chk("redirect_blocks_req", 32'(bus.imem_req_valid_o), 32'd0);
                if (delivered && r.kind != 2) m_dropped++;
                m_dropped += m_buffered;
                m_buffered = 0;
                foreach (pend[i]) if (pend[i].kind == 0) pend[i].kind = 1;
                exp_q.delete();
            end else begin
                if (delivered && r.kind == 0) begin
                    m_fetched++;
                    m_buffered++;
                end else if (delivered && r.kind == 1) begin
                    m_dropped++;
                end
                if (bus.dec_valid_o && bus.dec_ready_i) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL dec_unexpected: observed pc_plus4=%h expected=no entry",
                               bus.dec_pc_plus4_o);
                    end
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("dec_instr", bus.dec_instr_o, e.instr);
                        chk("dec_pc_plus4", bus.dec_pc_plus4_o, e.pc_plus4);
                    end
                    m_buffered--;
                end
            end
            if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
                pend.push_back('{addr: bus.imem_req_addr_o, due: cyc + mem_lat, kind: 0});
                exp_q.push_back('{instr: instr_of(bus.imem_req_addr_o),
                                  pc_plus4: bus.imem_req_addr_o + 32'd4});
            end
        end
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_req_valid"}, 32'(bus.imem_req_valid_o), 32'd0);
        chk({pfx, "_req_addr"},  bus.imem_req_addr_o, RESET_PC);
        chk({pfx, "_dec_valid"}, 32'(bus.dec_valid_o), 32'd0);
        chk({pfx, "_dec_instr"}, bus.dec_instr_o, 32'd0);
        chk({pfx, "_dec_pc4"},   bus.dec_pc_plus4_o, 32'd0);
        chk({pfx, "_count"},     32'(bus.count_o), 32'd0);
    endtask

    initial begin
        int          first;
        int          gaps;
        int          stable;
        bit          found;
        logic [31:0] hold_addr;

        bus.fetch_en_i       = 1'b0;
        bus.redirect_i       = 1'b0;
        bus.redirect_pc_i    = 32'h0;
        bus.imem_req_ready_i = 1'b1;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = 32'h0;
        bus.dec_ready_i      = 1'b0;

        #3;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        cycle();
        cycle();
        chk("idle_no_req", 32'(bus.imem_req_valid_o), 32'd0);

        // Streaming at one-cycle memory latency
        bus.dec_ready_i = 1'b1;
        bus.fetch_en_i  = 1'b1;
        mem_lat = 1;
        first = -1;
        for (int i = 1; i <= 20 && first < 0; i++) begin
            cycle();
            if (bus.dec_valid_o) first = i;
        end
        chk("stream_first_valid_cycle", 32'(first), 32'd3);
        chk("stream_first_instr", bus.dec_instr_o, instr_of(32'h0));
        chk("stream_first_pc4", bus.dec_pc_plus4_o, 32'h4);
        gaps = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (!bus.dec_valid_o) gaps++;
        end
        chk("stream_gapless", 32'(gaps), 32'd0);

        // Memory not ready: request must hold its address
        bus.imem_req_ready_i = 1'b0;
        cycle();
        hold_addr = bus.imem_req_addr_o;
        stable = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (bus.imem_req_valid_o && bus.imem_req_addr_o === hold_addr) stable++;
        end
        chk("req_addr_stable", 32'(stable), 32'd3);
        bus.imem_req_ready_i = 1'b1;

        // Decode backpressure fills the FIFO and throttles requests
        bus.dec_ready_i = 1'b0;
        repeat (10) cycle();
        chk("bp_count_full", 32'(bus.count_o), 32'(DEPTH));
        chk("bp_req_blocked", 32'(bus.imem_req_valid_o), 32'd0);
        chk("bp_dec_valid", 32'(bus.dec_valid_o), 32'd1);
        bus.dec_ready_i = 1'b1;
        repeat (6) cycle();
        bus.fetch_en_i = 1'b0;
        repeat (8) cycle();
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        chk("bp_count_zero", 32'(bus.count_o), 32'd0);

        // Redirect with two requests in flight
        mem_lat = 5;
        bus.fetch_en_i = 1'b1;
        repeat (3) cycle();
        chk("flight_cap_blocks", 32'(bus.imem_req_valid_o), 32'd0);
        chk("flight_issued", 32'(pend.size()), 32'd2);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h100;
        mem_lat = 1;
        cycle();
        bus.redirect_i = 1'b0;
        chk("flight_dec_valid", 32'(bus.dec_valid_o), 32'd0);
        chk("flight_addr", bus.imem_req_addr_o, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (bus.dec_valid_o) begin
                found = 1'b1;
                chk("flight_first_pc4", bus.dec_pc_plus4_o, 32'h104);
            end
        end
        chk("flight_found", 32'(found), 32'd1);
        bus.fetch_en_i = 1'b0;
        repeat (8) cycle();
        chk("flight_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back redirects, last wins, then PC wraps past 2^32
        bus.fetch_en_i = 1'b1;
        cycle();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h200;
        cycle();
        bus.redirect_pc_i = 32'hFFFF_FFF8;
        cycle();
        bus.redirect_i = 1'b0;
        chk("b2b_addr", bus.imem_req_addr_o, 32'hFFFF_FFF8);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (bus.dec_valid_o) begin
                found = 1'b1;
                chk("b2b_first_pc4", bus.dec_pc_plus4_o, 32'hFFFF_FFFC);
            end
        end
        chk("b2b_found", 32'(found), 32'd1);
        repeat (6) cycle();
        bus.fetch_en_i = 1'b0;
        repeat (8) cycle();
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Redirect coinciding with a response while the queue is fully reserved
        bus.dec_ready_i = 1'b0;
        mem_lat = 2;
        bus.fetch_en_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (pend.size() == 2 && pend[0].due <= cyc && bus.count_o >= 2) found = 1'b1;
            else cycle();
        end
        chk("coinc_found", 32'(found), 32'd1);
        chk("coinc_reserved", 32'(bus.imem_req_valid_o), 32'd0);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h400;
        cycle();
        bus.redirect_i = 1'b0;
        chk("coinc_count", 32'(bus.count_o), 32'd0);
        chk("coinc_dec_valid", 32'(bus.dec_valid_o), 32'd0);
        repeat (10) cycle();
        chk("coinc_refill", 32'(bus.count_o), 32'(DEPTH));
        chk("coinc_head_pc4", bus.dec_pc_plus4_o, 32'h404);
        bus.dec_ready_i = 1'b1;
        bus.fetch_en_i  = 1'b0;
        repeat (12) cycle();
        chk("coinc_drained", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'(m_fetched));
        chk("perf_dropped", perf_dropped, 32'(m_dropped));
`endif

        // Reset with two requests outstanding; late responses must be ignored
        mem_lat = 6;
        bus.fetch_en_i = 1'b1;
        repeat (4) cycle();
        chk("rst_setup", 32'(pend.size()), 32'd2);
        rst_i = 1'b0;
        #1;
        check_reset_outputs("midrst");
        bus.fetch_en_i = 1'b0;
        cycle();
        rst_i = 1'b1;
        repeat (10) cycle();
        chk("midrst_late_count", 32'(bus.count_o), 32'd0);
        chk("midrst_late_valid", 32'(bus.dec_valid_o), 32'd0);
        mem_lat = 1;
        bus.fetch_en_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (bus.imem_req_valid_o) begin
                found = 1'b1;
                chk("midrst_first_addr", bus.imem_req_addr_o, RESET_PC);
            end
        end
        chk("midrst_found", 32'(found), 32'd1);
        repeat (6) cycle();
        bus.fetch_en_i = 1'b0;
        repeat (8) cycle();
        chk("midrst_drained", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_EN
        chk("perf_fetched_after_rst", perf_fetched, 32'(m_fetched));
        chk("perf_dropped_after_rst", perf_dropped, 32'(m_dropped));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
